btn_debounce_pulse: RTL

BTN_DEBOUNCE_PULSE -- requirements
Module: btn_debounce_pulse

---
 rtl/btn_debounce_pulse.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/btn_debounce_pulse.sv
// Two-button front end: synchronize, debounce and turn each press into step pulses
// with hold-then-auto-repeat; a busy button locks the other one out.
module btn_db_chan #(
    parameter int DB_TICKS     = 4,
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn_raw,
    input  logic other_lvl,
    output logic lvl,
    output logic pulse
);
    localparam int DBW  = $clog2(DB_TICKS + 1);
    localparam int TMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_e;

    logic           sync1_q, sync2_q;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           lvl_q, lvl_d, lvl_prev_q;
    logic           fall;
    state_e         state_q, state_d;
    logic [TW-1:0]  tcnt_q, tcnt_d;
    logic           pulse_q, pulse_d;

    always_comb begin
        db_cnt_d = db_cnt_q;
        lvl_d    = lvl_q;
        if (tick) begin
            if (sync2_q != lvl_q) begin
                if (db_cnt_q == DBW'(DB_TICKS - 1)) begin
                    lvl_d    = ~lvl_q;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DBW'(1);
                end
            end else begin
                db_cnt_d = '0;
            end
        end
    end

    // Release is acted on the same edge the level drops, so a repeat slot
    // coinciding with the release never fires.
    assign fall = lvl_q & ~lvl_d;

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        pulse_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                tcnt_d = '0;
                if (lvl_q && !lvl_prev_q && !other_lvl && !fall) begin
                    state_d = HOLD;
                    pulse_d = 1'b1;
                end
            end
            HOLD, REPEAT: begin
                if (fall || !lvl_q) begin
                    state_d = IDLE;
                    tcnt_d  = '0;
                end else if (tick) begin
                    if ((state_q == HOLD   && tcnt_q == TW'(HOLD_TICKS - 1)) ||
                        (state_q == REPEAT && tcnt_q == TW'(REPEAT_TICKS - 1))) begin
                        state_d = REPEAT;
                        tcnt_d  = '0;
                        pulse_d = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tcnt_d  = '0;
            end
        endcase
        pulse_d = pulse_d & ~pulse_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_cnt_q   <= '0;
            lvl_q      <= 1'b0;
            lvl_prev_q <= 1'b0;
            state_q    <= IDLE;
            tcnt_q     <= '0;
            pulse_q    <= 1'b0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            db_cnt_q   <= db_cnt_d;
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_q;
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            pulse_q    <= pulse_d;
        end
    end

    assign lvl   = lvl_q;
    assign pulse = pulse_q;
endmodule

module btn_debounce_pulse #(
    parameter int DB_TICKS     = 4,
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 100
) (
    input  logic clk_100mhz,
    input  logic rst_n,
    input  logic tick_1khz,
    input  logic btn_accel,
    input  logic btn_decel,
    output logic accel_pulse,
    output logic decel_pulse,
    output logic accel_level,
    output logic decel_level
);
    // Channel 0 = accelerate, channel 1 = decelerate.
    logic [1:0] raw, lvl, pls;

    assign raw = {btn_decel, btn_accel};

    for (genvar i = 0; i < 2; i++) begin : g_chan
        btn_db_chan #(
            .DB_TICKS    (DB_TICKS),
            .HOLD_TICKS  (HOLD_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS)
        ) u_chan (
            .clk      (clk_100mhz),
            .rst_n    (rst_n),
            .tick     (tick_1khz),
            .btn_raw  (raw[i]),
            .other_lvl(lvl[1-i]),
            .lvl      (lvl[i]),
            .pulse    (pls[i])
        );
    end

    assign accel_pulse = pls[0];
    assign decel_pulse = pls[1];
    assign accel_level = lvl[0];
    assign decel_level = lvl[1];
endmodule
